riscv_stream_out_fifo: RTL

- Per-channel output buffer directly downstream of the RISC-V memory-mapped stream port.
- Captures each one-cycle write pulse (val_in with din) that firmware produces by storing to a stream address.
- Holds the words in a small first-word-fall-through FIFO and presents them to the next page as a level-valid stream.
- Drives ready_upward back to the memory port's ready_downward input, which gates completion of the firmware store.

---
 rtl/riscv_stream_out_fifo.sv | 88 ++++++++
 1 files changed

// File: rtl/riscv_stream_out_fifo.sv
// First-word-fall-through output buffer between the RISC-V stream port and the next page.
// One-cycle write pulses are queued and presented as a level-valid stream with asynchronous head read.
module riscv_stream_out_fifo #(
    parameter int    DWIDTH     = 32,
    parameter int    DEPTH_LOG2 = 4,
    parameter int    AF_LEVEL   = 12,
    parameter string RAM_TYPE   = "distributed"
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic [DWIDTH-1:0]     din,
    input  logic                  val_in,
    output logic                  ready_upward,
    output logic [DWIDTH-1:0]     dout,
    output logic                  val_out,
    input  logic                  ready_downward,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  almost_full,
    output logic                  overflow
);

    localparam int               DEPTH  = 1 << DEPTH_LOG2;
    localparam int               PW     = DEPTH_LOG2 + 1;
    localparam logic [PW-1:0]    AF_CNT = PW'(AF_LEVEL);

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic          overflow_q, overflow_d;
    logic          empty, full, we, re;

    // Extra pointer MSB separates the full case from the empty case when the low bits match.
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[DEPTH_LOG2-1:0] == rd_ptr_q[DEPTH_LOG2-1:0]) &&
                   (wr_ptr_q[DEPTH_LOG2] != rd_ptr_q[DEPTH_LOG2]);
    assign we    = val_in && !full;
    assign re    = ready_downward && !empty;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        overflow_d = overflow_q;
        if (we) wr_ptr_d = wr_ptr_q + 1'b1;
        if (re) rd_ptr_d = rd_ptr_q + 1'b1;
        // A strobe while full is lost even if a read frees a slot this same cycle.
        if (val_in && full) overflow_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            overflow_q <= overflow_d;
        end
    end

    generate
        if (RAM_TYPE == "registers") begin : g_ff_store
            (* ram_style = "registers" *)
            logic [DWIDTH-1:0] mem [DEPTH];

            always_ff @(posedge clk) begin
                if (we) mem[wr_ptr_q[DEPTH_LOG2-1:0]] <= din;
            end

            assign dout = mem[rd_ptr_q[DEPTH_LOG2-1:0]];
        end else begin : g_lut_store
            (* ram_style = "distributed" *)
            logic [DWIDTH-1:0] mem [DEPTH];

            always_ff @(posedge clk) begin
                if (we) mem[wr_ptr_q[DEPTH_LOG2-1:0]] <= din;
            end

            assign dout = mem[rd_ptr_q[DEPTH_LOG2-1:0]];
        end
    endgenerate

    assign count        = wr_ptr_q - rd_ptr_q;
    assign val_out      = !empty;
    assign ready_upward = !full;
    assign almost_full  = (count >= AF_CNT);
    assign overflow     = overflow_q;

endmodule
